ongorucu_guncelleme_denetleyici: RTL and testbench
==================================================

Name: ongorucu_guncelleme_denetleyici

Overview:
Sequencer and arbiter for the single-ported pattern/target table of the gshare predictor (ongorucu).
- After reset it walks the table and initialises every entry.
- It queues branch resolutions from the execute stage (yurut_*) in a small FIFO and maintains the committed global history.
- It grants the table port to updates only when fetch (getir_*) is not reading, with bounded starvation.
- It flags mispredictions so the front end can restore history.

Parameters:
PS_W, 32, program counter / target width
GHR_W, 8, global history width = table index width (2^GHR_W entries)
FIFO_DERINLIK, 4, update FIFO depth (power of two, >=2)
ACLIK_SINIRI, 3, max consecutive cycles a non-empty FIFO head may be deferred by fetch reads

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
getir_gecerli  input  1  fetch lookup uses table port this cycle
yurut_gecerli  input  1  resolved branch valid
yurut_ps  input  PS_W  resolved branch PC
yurut_dallan  input  1  actual direction (1 = taken)
yurut_dallan_ps  input  PS_W  actual target
yurut_ongoru  input  1  direction that was predicted
yurut_hazir  output  1  FIFO can accept (= !full)
getir_durdur  output  1  fetch must stall; port taken by forced update
tablo_yaz_gecerli  output  1  table write this cycle
tablo_yaz_temizle  output  1  write is an init write (counter := 2'b01, target := 0)
tablo_yaz_indeks  output  GHR_W  write index
tablo_yaz_dallan  output  1  counter direction (inc if 1, dec if 0)
tablo_yaz_hedef  output  PS_W  target to store
ghr_kayit  output  GHR_W  committed global history
yanlis_ongoru  output  1  one-cycle mispredict pulse
duzeltilmis_ghr  output  GHR_W  corrected history, valid with yanlis_ongoru
hazir  output  1  init complete
tasma  output  1  sticky overflow flag

Behaviour:
- Reset (rst high at edge): all outputs 0, ghr 0, FIFO empty, init counter 0, state TEMIZLE. Reset mid-operation flushes FIFO, discards pending writes and restarts TEMIZLE.
- States: TEMIZLE -> CALIS.
  - TEMIZLE: one registered write per cycle, with tablo_yaz_gecerli=1, tablo_yaz_temizle=1, indeks 0..2^GHR_W-1 ascending.
  - First init write is visible in the cycle after the first edge with rst low.
  - After the write of index 2^GHR_W-1, go to CALIS; hazir=1 from the next cycle on.
  - In TEMIZLE, yurut_hazir=0, getir_durdur=1, and yurut_gecerli is ignored.
- Enqueue (CALIS): on an edge with yurut_gecerli & yurut_hazir:
  - push {indeks = yurut_ps[GHR_W+1:2] ^ ghr, yurut_dallan, yurut_dallan_ps};
  - ghr <= {ghr[GHR_W-2:0], yurut_dallan}.
  - yurut_hazir depends only on the full flag. Simultaneous push+pop while full is never accepted.
  - yurut_gecerli while !yurut_hazir in CALIS: entry dropped, ghr unchanged, tasma <= 1. tasma clears only on rst.
- Mispredict: on any accepted enqueue with yurut_dallan != yurut_ongoru, in the next cycle:
  - yanlis_ongoru=1;
  - duzeltilmis_ghr = the new ghr.
  - Otherwise yanlis_ongoru=0.
- Arbitration (CALIS, FIFO non-empty):
  - getir_gecerli=0: pop head at this edge.
  - getir_gecerli=1 and bekleme < ACLIK_SINIRI: defer, bekleme++.
  - getir_gecerli=1 and bekleme == ACLIK_SINIRI: pop anyway; getir_durdur=1 combinationally this cycle.
  - bekleme resets to 0 on every pop and when the FIFO is empty.
- Write timing:
  - A pop at edge E drives tablo_yaz_* (registered) in the cycle after E, with tablo_yaz_temizle=0.
  - tablo_yaz_gecerli is 0 in cycles with no pop at the preceding edge.
  - Minimum latency: accepting edge E0, pop at E1, write visible after E1.
- Empty FIFO: push and pop are never the same entry in one edge; a pushed entry is poppable from the next edge.
- Pointers wrap modulo FIFO_DERINLIK; count width is clog2(FIFO_DERINLIK)+1.

Decomposition:
- Shared package ongorucu_pkg: PS_W, GHR_W defaults; 2-bit counter init constant 2'b01; state enum {TEMIZLE, CALIS}; FIFO entry struct {indeks, dallan, hedef}.
- One sub-module: ongorucu_fifo, a synchronous FIFO with push/pop/full/empty/count ports, reused elsewhere.

Test Plan:
- Init walk: rst high 2 cycles, release -> exactly 256 writes with temizle=1, indeks 0..255 in order; hazir=1 in the next cycle; yurut_hazir=0 throughout.
- Single update: after hazir, ghr=0, yurut_ps=0x100, dallan=1, ongoru=1, hedef=0x104, getir_gecerli=0 -> one cycle later tablo_yaz_gecerli=1, indeks=0x40, hedef=0x00000104, dallan=1; ghr_kayit=0x01; yanlis_ongoru stays 0.
- Mispredict: ghr=0x01, yurut_ps=0x200, dallan=0, ongoru=1 -> next cycle yanlis_ongoru=1, duzeltilmis_ghr=0x02; write indeks=0x80^0x01=0x81.
- Starvation bound: getir_gecerli held 1, one entry queued -> deferred 3 cycles, 4th cycle getir_durdur=1 and pop, write visible next cycle.
- Full/overflow: getir_gecerli=1, push 4 entries -> yurut_hazir=0; a 5th yurut_gecerli -> tasma=1, ghr unchanged, entry absent from the later write sequence.
- Reset mid-drain: 3 entries queued, assert rst one cycle -> no update writes appear; init walk restarts from indeks 0; tasma=0, ghr_kayit=0.

Source files
------------

// File: rtl/ongorucu_pkg.sv
// Shared types and defaults for the gshare predictor table update path.
package ongorucu_pkg;

  localparam int PS_W_VARS  = 32;
  localparam int GHR_W_VARS = 8;

  // Value an init write loads into the 2-bit counter (weakly not-taken).
  localparam logic [1:0] SAYAC_ILK = 2'b01;

  typedef enum logic {
    TEMIZLE = 1'b0,
    CALIS   = 1'b1
  } durum_t;

  typedef struct packed {
    logic [GHR_W_VARS-1:0] indeks;
    logic                  dallan;
    logic [PS_W_VARS-1:0]  hedef;
  } girdi_t;

endpackage

// File: rtl/ongorucu_fifo.sv
// Synchronous FIFO. Head data is combinational; push while full and pop while empty are ignored.
module ongorucu_fifo #(
  parameter int VERI_W   = 41,
  parameter int DERINLIK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [VERI_W-1:0]         push_veri,
  input  logic                      pop,
  output logic [VERI_W-1:0]         bas_veri,
  output logic                      dolu,
  output logic                      bos,
  output logic [$clog2(DERINLIK):0] sayi
);

  localparam int ADR_W  = $clog2(DERINLIK);
  localparam int SAYI_W = ADR_W + 1;

  logic [VERI_W-1:0] mem_q [DERINLIK];
  logic [VERI_W-1:0] mem_d [DERINLIK];
  logic [ADR_W-1:0]  yaz_ptr_q, yaz_ptr_d;
  logic [ADR_W-1:0]  oku_ptr_q, oku_ptr_d;
  logic [SAYI_W-1:0] sayi_q, sayi_d;
  logic              push_ok, pop_ok;

  assign dolu     = (sayi_q == SAYI_W'(DERINLIK));
  assign bos      = (sayi_q == '0);
  assign sayi     = sayi_q;
  assign bas_veri = mem_q[oku_ptr_q];
  assign push_ok  = push & ~dolu;
  assign pop_ok   = pop & ~bos;

  always_comb begin
    mem_d     = mem_q;
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayi_d    = sayi_q;
    if (push_ok) begin
      mem_d[yaz_ptr_q] = push_veri;
      yaz_ptr_d        = yaz_ptr_q + ADR_W'(1);
    end
    if (pop_ok) begin
      oku_ptr_d = oku_ptr_q + ADR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   sayi_d = sayi_q + SAYI_W'(1);
      2'b01:   sayi_d = sayi_q - SAYI_W'(1);
      default: sayi_d = sayi_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayi_q    <= '0;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayi_q    <= sayi_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ongorucu_guncelleme_denetleyici.sv
// Init walk, update queueing and table-port arbitration for the gshare pattern/target table.
module ongorucu_guncelleme_denetleyici
  import ongorucu_pkg::*;
#(
  parameter int PS_W          = PS_W_VARS,
  parameter int GHR_W         = GHR_W_VARS,
  parameter int FIFO_DERINLIK = 4,
  parameter int ACLIK_SINIRI  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             getir_gecerli,
  input  logic             yurut_gecerli,
  input  logic [PS_W-1:0]  yurut_ps,
  input  logic             yurut_dallan,
  input  logic [PS_W-1:0]  yurut_dallan_ps,
  input  logic             yurut_ongoru,
  output logic             yurut_hazir,
  output logic             getir_durdur,
  output logic             tablo_yaz_gecerli,
  output logic             tablo_yaz_temizle,
  output logic [GHR_W-1:0] tablo_yaz_indeks,
  output logic             tablo_yaz_dallan,
  output logic [PS_W-1:0]  tablo_yaz_hedef,
  output logic [GHR_W-1:0] ghr_kayit,
  output logic             yanlis_ongoru,
  output logic [GHR_W-1:0] duzeltilmis_ghr,
  output logic             hazir,
  output logic             tasma
);

  localparam int GIRDI_W = GHR_W + 1 + PS_W;
  localparam int BEK_W   = (ACLIK_SINIRI > 0) ? $clog2(ACLIK_SINIRI + 1) : 1;

  durum_t              durum_q, durum_d;
  logic [GHR_W-1:0]    ilk_idx_q, ilk_idx_d;
  logic [GHR_W-1:0]    ghr_q, ghr_d;
  logic [BEK_W-1:0]    bekleme_q, bekleme_d;
  logic                tasma_q, tasma_d;
  logic                hazir_q, hazir_d;
  logic                yanlis_q, yanlis_d;
  logic [GHR_W-1:0]    duz_ghr_q, duz_ghr_d;
  logic                yaz_gecerli_q, yaz_gecerli_d;
  logic                yaz_temizle_q, yaz_temizle_d;
  logic [GHR_W-1:0]    yaz_indeks_q, yaz_indeks_d;
  logic                yaz_dallan_q, yaz_dallan_d;
  logic [PS_W-1:0]     yaz_hedef_q, yaz_hedef_d;

  logic                fifo_push, fifo_pop, fifo_dolu, fifo_bos;
  logic [$clog2(FIFO_DERINLIK):0] fifo_sayi;
  logic [GIRDI_W-1:0]  push_veri, bas_veri;
  logic [GHR_W-1:0]    yeni_indeks, yeni_ghr;
  logic                sinirda, zorla;
  logic                ps_unused;

  // Queue traffic only starts once hazir is up, so the last init write never overlaps an update.
  assign sinirda     = (bekleme_q == BEK_W'(ACLIK_SINIRI));
  assign fifo_push   = hazir_q & yurut_gecerli & ~fifo_dolu;
  assign fifo_pop    = hazir_q & ~fifo_bos & (~getir_gecerli | sinirda);
  assign zorla       = hazir_q & ~fifo_bos & getir_gecerli & sinirda;
  assign yeni_indeks = yurut_ps[GHR_W+1:2] ^ ghr_q;
  assign yeni_ghr    = {ghr_q[GHR_W-2:0], yurut_dallan};
  assign push_veri   = {yeni_indeks, yurut_dallan, yurut_dallan_ps};
  assign ps_unused   = ^{yurut_ps[PS_W-1:GHR_W+2], yurut_ps[1:0], fifo_sayi};

  ongorucu_fifo #(
    .VERI_W   (GIRDI_W),
    .DERINLIK (FIFO_DERINLIK)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_veri (push_veri),
    .pop       (fifo_pop),
    .bas_veri  (bas_veri),
    .dolu      (fifo_dolu),
    .bos       (fifo_bos),
    .sayi      (fifo_sayi)
  );

  always_comb begin
    durum_d       = durum_q;
    ilk_idx_d     = ilk_idx_q;
    ghr_d         = ghr_q;
    bekleme_d     = bekleme_q;
    tasma_d       = tasma_q;
    hazir_d       = hazir_q | (durum_q == CALIS);
    yanlis_d      = 1'b0;
    duz_ghr_d     = '0;
    yaz_gecerli_d = 1'b0;
    yaz_temizle_d = 1'b0;
    yaz_indeks_d  = '0;
    yaz_dallan_d  = 1'b0;
    yaz_hedef_d   = '0;

    case (durum_q)
      TEMIZLE: begin
        yaz_gecerli_d = 1'b1;
        yaz_temizle_d = 1'b1;
        yaz_indeks_d  = ilk_idx_q;
        ilk_idx_d     = ilk_idx_q + GHR_W'(1);
        if (ilk_idx_q == '1) durum_d = CALIS;
      end
      CALIS: begin
        if (fifo_pop) begin
          yaz_gecerli_d = 1'b1;
          {yaz_indeks_d, yaz_dallan_d, yaz_hedef_d} = bas_veri;
        end
      end
      default: durum_d = TEMIZLE;
    endcase

    if (fifo_push) begin
      ghr_d = yeni_ghr;
      if (yurut_dallan != yurut_ongoru) begin
        yanlis_d  = 1'b1;
        duz_ghr_d = yeni_ghr;
      end
    end
    if (hazir_q & yurut_gecerli & fifo_dolu) tasma_d = 1'b1;

    if (fifo_pop || fifo_bos) bekleme_d = '0;
    else if (getir_gecerli)   bekleme_d = bekleme_q + BEK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q       <= TEMIZLE;
      ilk_idx_q     <= '0;
      ghr_q         <= '0;
      bekleme_q     <= '0;
      tasma_q       <= 1'b0;
      hazir_q       <= 1'b0;
      yanlis_q      <= 1'b0;
      duz_ghr_q     <= '0;
      yaz_gecerli_q <= 1'b0;
      yaz_temizle_q <= 1'b0;
      yaz_indeks_q  <= '0;
      yaz_dallan_q  <= 1'b0;
      yaz_hedef_q   <= '0;
    end else begin
      durum_q       <= durum_d;
      ilk_idx_q     <= ilk_idx_d;
      ghr_q         <= ghr_d;
      bekleme_q     <= bekleme_d;
      tasma_q       <= tasma_d;
      hazir_q       <= hazir_d;
      yanlis_q      <= yanlis_d;
      duz_ghr_q     <= duz_ghr_d;
      yaz_gecerli_q <= yaz_gecerli_d;
      yaz_temizle_q <= yaz_temizle_d;
      yaz_indeks_q  <= yaz_indeks_d;
      yaz_dallan_q  <= yaz_dallan_d;
      yaz_hedef_q   <= yaz_hedef_d;
    end
  end

  // Fetch is held off for the whole init walk, but not while reset itself is asserted.
  assign getir_durdur      = (~hazir_q & ~rst) | zorla;
  assign yurut_hazir       = hazir_q & ~fifo_dolu;
  assign tablo_yaz_gecerli = yaz_gecerli_q;
  assign tablo_yaz_temizle = yaz_temizle_q;
  assign tablo_yaz_indeks  = yaz_indeks_q;
  assign tablo_yaz_dallan  = yaz_dallan_q;
  assign tablo_yaz_hedef   = yaz_hedef_q;
  assign ghr_kayit         = ghr_q;
  assign yanlis_ongoru     = yanlis_q;
  assign duzeltilmis_ghr   = duz_ghr_q;
  assign hazir             = hazir_q;
  assign tasma             = tasma_q;

endmodule

// File: tb/tb_ongorucu_guncelleme_denetleyici.sv
// Directed bench for the predictor update controller; expected table writes and mispredict pulses go through queues.
module tb_ongorucu_guncelleme_denetleyici;

  typedef struct packed {
    logic        temizle;
    logic [7:0]  indeks;
    logic        dallan;
    logic [31:0] hedef;
  } bek_yazma_t;

  logic        clk, rst, getir_gecerli, yurut_gecerli, yurut_dallan, yurut_ongoru;
  logic [31:0] yurut_ps, yurut_dallan_ps;
  logic        yurut_hazir, getir_durdur, tablo_yaz_gecerli, tablo_yaz_temizle, tablo_yaz_dallan;
  logic [7:0]  tablo_yaz_indeks, ghr_kayit, duzeltilmis_ghr;
  logic [31:0] tablo_yaz_hedef;
  logic        yanlis_ongoru, hazir, tasma;

  bek_yazma_t  yazma_q[$];
  logic [7:0]  yanlis_q[$];
  int          toplam = 0;
  int          gecen  = 0;

  ongorucu_guncelleme_denetleyici dut (
    .clk               (clk),
    .rst               (rst),
    .getir_gecerli     (getir_gecerli),
    .yurut_gecerli     (yurut_gecerli),
    .yurut_ps          (yurut_ps),
    .yurut_dallan      (yurut_dallan),
    .yurut_dallan_ps   (yurut_dallan_ps),
    .yurut_ongoru      (yurut_ongoru),
    .yurut_hazir       (yurut_hazir),
    .getir_durdur      (getir_durdur),
    .tablo_yaz_gecerli (tablo_yaz_gecerli),
    .tablo_yaz_temizle (tablo_yaz_temizle),
    .tablo_yaz_indeks  (tablo_yaz_indeks),
    .tablo_yaz_dallan  (tablo_yaz_dallan),
    .tablo_yaz_hedef   (tablo_yaz_hedef),
    .ghr_kayit         (ghr_kayit),
    .yanlis_ongoru     (yanlis_ongoru),
    .duzeltilmis_ghr   (duzeltilmis_ghr),
    .hazir             (hazir),
    .tasma             (tasma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    toplam++;
    if (gercek === beklenen) gecen++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", ad, gercek, beklenen, $time);
  endtask

  // Monitor: every table write and every mispredict pulse must match the head of its queue.
  always @(negedge clk) begin
    bek_yazma_t e;
    logic [7:0] g;
    if (tablo_yaz_gecerli === 1'b1) begin
      if (yazma_q.size() == 0) begin
        toplam++;
        $display("FAIL yazma_beklenmedik: got indeks %0h temizle %0b expected no write (t=%0t)",
                 tablo_yaz_indeks, tablo_yaz_temizle, $time);
      end else begin
        e = yazma_q.pop_front();
        chk("yazma_temizle", 64'(tablo_yaz_temizle), 64'(e.temizle));
        chk("yazma_indeks", 64'(tablo_yaz_indeks), 64'(e.indeks));
        if (!e.temizle) begin
          chk("yazma_dallan", 64'(tablo_yaz_dallan), 64'(e.dallan));
          chk("yazma_hedef", 64'(tablo_yaz_hedef), 64'(e.hedef));
        end
      end
    end
    if (yanlis_ongoru === 1'b1) begin
      if (yanlis_q.size() == 0) begin
        toplam++;
        $display("FAIL yanlis_beklenmedik: got pulse ghr %0h expected none (t=%0t)", duzeltilmis_ghr, $time);
      end else begin
        g = yanlis_q.pop_front();
        chk("duzeltilmis_ghr", 64'(duzeltilmis_ghr), 64'(g));
      end
    end
  end

  task automatic tik();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] ps, input logic dallan, input logic ongoru, input logic [31:0] hedef);
    yurut_ps        = ps;
    yurut_dallan    = dallan;
    yurut_ongoru    = ongoru;
    yurut_dallan_ps = hedef;
    yurut_gecerli   = 1'b1;
    tik();
    yurut_gecerli   = 1'b0;
  endtask

  task automatic ilk_beklentiler();
    for (int i = 0; i < 256; i++) yazma_q.push_back({1'b1, 8'(i), 1'b0, 32'h0});
  endtask

  // Called right after rst drops; hazir is due 257 edges later.
  task automatic init_bekle(input string ad);
    int  n;
    bit  yh_hata;
    yh_hata = 1'b0;
    for (n = 1; n <= 400; n++) begin
      tik();
      if (!hazir && yurut_hazir) yh_hata = 1'b1;
      if (hazir) break;
    end
    chk({ad, "_hazir_kenar"}, 64'(n), 64'd257);
    chk({ad, "_yurut_hazir_0"}, 64'(yh_hata), 64'd0);
    chk({ad, "_yazma_kalan"}, 64'(yazma_q.size()), 64'd0);
  endtask

  logic [31:0] d_ps    [4] = '{32'h000, 32'h004, 32'h3FC, 32'h010};
  logic        d_dal   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] d_hedef [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [7:0]  d_idx   [4] = '{8'h05, 8'h0A, 8'hE9, 8'h29};

  initial begin
    rst = 1'b1; getir_gecerli = 1'b0; yurut_gecerli = 1'b0;
    yurut_ps = '0; yurut_dallan = 1'b0; yurut_dallan_ps = '0; yurut_ongoru = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_yaz_gecerli", 64'(tablo_yaz_gecerli), 64'd0);
    chk("rst_hazir", 64'(hazir), 64'd0);
    chk("rst_ghr", 64'(ghr_kayit), 64'd0);
    chk("rst_tasma", 64'(tasma), 64'd0);
    chk("rst_yurut_hazir", 64'(yurut_hazir), 64'd0);
    ilk_beklentiler();
    rst = 1'b0;
    init_bekle("init1");

    // single update, predicted correctly
    yazma_q.push_back({1'b0, 8'h40, 1'b1, 32'h104});
    enq(32'h100, 1'b1, 1'b1, 32'h104);
    chk("tek_gecikme0", 64'(tablo_yaz_gecerli), 64'd0);
    chk("tek_ghr", 64'(ghr_kayit), 64'h01);
    chk("tek_yanlis", 64'(yanlis_ongoru), 64'd0);
    tik();
    chk("tek_gecikme1", 64'(tablo_yaz_gecerli), 64'd1);

    // mispredict
    yazma_q.push_back({1'b0, 8'h81, 1'b0, 32'hABC});
    yanlis_q.push_back(8'h02);
    enq(32'h200, 1'b0, 1'b1, 32'hABC);
    chk("yanlis_darbe", 64'(yanlis_ongoru), 64'd1);
    chk("yanlis_ghr", 64'(ghr_kayit), 64'h02);
    repeat (3) tik();

    // starvation bound with fetch reading continuously
    getir_gecerli = 1'b1;
    yazma_q.push_back({1'b0, 8'hC1, 1'b1, 32'h1234});
    enq(32'h30C, 1'b1, 1'b1, 32'h1234);
    chk("aclik_durdur0", 64'(getir_durdur), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      tik();
      chk("aclik_durdur", 64'(getir_durdur), 64'(k == 3));
      chk("aclik_erteleme", 64'(tablo_yaz_gecerli), 64'd0);
    end
    tik();
    chk("aclik_yazma", 64'(tablo_yaz_gecerli), 64'd1);
    chk("aclik_durdur_son", 64'(getir_durdur), 64'd0);
    chk("aclik_ghr", 64'(ghr_kayit), 64'h05);

    // fill to full, then one dropped resolution
    for (int j = 0; j < 4; j++) begin
      yazma_q.push_back({1'b0, d_idx[j], d_dal[j], d_hedef[j]});
      enq(d_ps[j], d_dal[j], d_dal[j], d_hedef[j]);
    end
    chk("dolu_yurut_hazir", 64'(yurut_hazir), 64'd0);
    chk("dolu_ghr", 64'(ghr_kayit), 64'h5B);
    chk("dolu_tasma_once", 64'(tasma), 64'd0);
    enq(32'h020, 1'b0, 1'b0, 32'h55);
    chk("tasma_bayrak", 64'(tasma), 64'd1);
    chk("tasma_ghr", 64'(ghr_kayit), 64'h5B);
    getir_gecerli = 1'b0;
    repeat (10) tik();
    chk("bosalma_kalan", 64'(yazma_q.size()), 64'd0);
    chk("tasma_yapiskan", 64'(tasma), 64'd1);

    // reset while entries are still queued
    getir_gecerli = 1'b1;
    enq(32'h040, 1'b1, 1'b1, 32'h66);
    enq(32'h044, 1'b0, 1'b0, 32'h77);
    enq(32'h048, 1'b1, 1'b1, 32'h88);
    ilk_beklentiler();
    rst = 1'b1;
    tik();
    rst = 1'b0;
    chk("rst2_tasma", 64'(tasma), 64'd0);
    chk("rst2_ghr", 64'(ghr_kayit), 64'd0);
    chk("rst2_hazir", 64'(hazir), 64'd0);
    chk("rst2_yaz_gecerli", 64'(tablo_yaz_gecerli), 64'd0);
    init_bekle("init2");
    repeat (3) tik();
    chk("yanlis_kalan", 64'(yanlis_q.size()), 64'd0);
    chk("yazma_son_kalan", 64'(yazma_q.size()), 64'd0);

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
